// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: stall/flush request and control bundle between the pipeline stages and pipeline_ctrl.
// STALL_PERF_EN adds the stall-cycle performance counter signal.
interface pipeline_ctrl_if #(parameter int PC_W = 32) ();
  logic            stallreq_id_i;
  logic            stallreq_ex_i;
  logic            stallreq_mem_i;
  logic            flush_req_i;
  logic [PC_W-1:0] flush_pc_i;
  logic [5:0]      stall_o;
  logic            flush_o;
  logic [PC_W-1:0] new_pc_o;
  logic            fault_o;
`ifdef STALL_PERF_EN
  logic [31:0]     perf_stall_cnt_o;
  modport master (output stallreq_id_i, stallreq_ex_i, stallreq_mem_i, flush_req_i, flush_pc_i,
                  input stall_o, flush_o, new_pc_o, fault_o, perf_stall_cnt_o);
  modport slave  (input stallreq_id_i, stallreq_ex_i, stallreq_mem_i, flush_req_i, flush_pc_i,
                  output stall_o, flush_o, new_pc_o, fault_o, perf_stall_cnt_o);
`else
  modport master (output stallreq_id_i, stallreq_ex_i, stallreq_mem_i, flush_req_i, flush_pc_i,
                  input stall_o, flush_o, new_pc_o, fault_o);
  modport slave  (input stallreq_id_i, stallreq_ex_i, stallreq_mem_i, flush_req_i, flush_pc_i,
                  output stall_o, flush_o, new_pc_o, fault_o);
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges stage stall requests, sequences branch flushes and runs a MEM-stall watchdog.
// STALL_PERF_EN adds a saturating count of stalled cycles.
module pipeline_ctrl #(
  parameter int PC_W           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {RUN, FLUSH, FAULT} state_t;
  state_t          state, state_n;
  logic            pend, pend_n, flush_n, fault_n, accept, timeout;
  logic [PC_W-1:0] pend_pc, pend_pc_n, new_pc_n;
  logic [CW-1:0]   cnt, cnt_n;
  wire mem = bus.stallreq_mem_i;
  assign accept  = state == RUN && (bus.flush_req_i || pend) && !mem;
  assign timeout = TIMEOUT_CYCLES != 0 && state == RUN && mem && cnt == LAST;
  // an accepted flush squashes the younger ID/EX stalls in the same cycle
  assign bus.stall_o = rst             ? 6'b000000 :
                       state == FAULT  ? 6'b111111 :
                       state == FLUSH || accept ? 6'b000000 :
                       mem             ? 6'b011111 :
                       bus.stallreq_ex_i ? 6'b001111 :
                       bus.stallreq_id_i ? 6'b000111 : 6'b000000;
  always_comb begin
    state_n   = state;
    pend_n    = pend;
    pend_pc_n = pend_pc;
    new_pc_n  = bus.new_pc_o;
    flush_n   = 1'b0;
    fault_n   = bus.fault_o;
    cnt_n     = '0;
    if (state == RUN) begin
      cnt_n = (mem && TIMEOUT_CYCLES != 0) ? cnt + 1'b1 : '0;
      if (timeout) begin
        state_n = FAULT;
        fault_n = 1'b1;
        pend_n  = 1'b0;
      end else if (accept) begin
        state_n  = FLUSH;
        flush_n  = 1'b1;
        new_pc_n = pend ? pend_pc : bus.flush_pc_i;
        pend_n   = 1'b0;
      end else if (bus.flush_req_i && !pend) begin
        pend_n    = 1'b1;
        pend_pc_n = bus.flush_pc_i;
      end
    end else begin
      state_n = state == FLUSH ? RUN : FAULT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pend         <= 1'b0;
      pend_pc      <= '0;
      cnt          <= '0;
      bus.flush_o  <= 1'b0;
      bus.new_pc_o <= '0;
      bus.fault_o  <= 1'b0;
    end else begin
      state        <= state_n;
      pend         <= pend_n;
      pend_pc      <= pend_pc_n;
      cnt          <= cnt_n;
      bus.flush_o  <= flush_n;
      bus.new_pc_o <= new_pc_n;
      bus.fault_o  <= fault_n;
    end
  end
`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) bus.perf_stall_cnt_o <= '0;
    else if (|bus.stall_o && bus.perf_stall_cnt_o != 32'hFFFF_FFFF) bus.perf_stall_cnt_o <= bus.perf_stall_cnt_o + 1'b1;
  end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random stimulus against a cycle-level reference model of the controller.
module tb_pipeline_ctrl;
  logic clk = 1'b0, rst;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  pipeline_ctrl_if #(.PC_W(32)) bus ();
  pipeline_ctrl #(.PC_W(32), .TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  bit          m_flush, m_fault, m_pend;
  logic [31:0] m_pc, m_pend_pc, m_perf;
  int          m_streak;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [5:0] exp_stall(input bit r, id, ex, mem, fr);
    int n;
    if (r) return 6'd0;
    if (m_fault) return 6'd63;
    if (m_flush || ((fr || m_pend) && !mem)) return 6'd0;
    n = mem ? 5 : ex ? 4 : id ? 3 : 0;
    return 6'((1 << n) - 1);
  endfunction
  task automatic step(input bit r, id, ex, mem, fr, input logic [31:0] pc);
    logic [5:0] es;
    rst = r; bus.stallreq_id_i = id; bus.stallreq_ex_i = ex; bus.stallreq_mem_i = mem;
    bus.flush_req_i = fr; bus.flush_pc_i = pc;
    #4;
    es = exp_stall(r, id, ex, mem, fr);
    chk("stall", 32'(bus.stall_o), 32'(es));
    @(posedge clk);
    if (r) begin
      m_flush = 0; m_fault = 0; m_pend = 0; m_pc = 0; m_streak = 0; m_perf = 0;
    end else begin
      if (es != 0 && m_perf != 32'hFFFF_FFFF) m_perf++;
      if (m_fault) m_flush = 0;
      else if (m_flush) begin m_flush = 0; m_streak = 0; end
      else begin
        m_streak = mem ? m_streak + 1 : 0;
        m_flush = 0;
        if (m_streak == 4) begin m_fault = 1; m_pend = 0; end
        else if ((fr || m_pend) && !mem) begin
          m_flush = 1; m_pc = m_pend ? m_pend_pc : pc; m_pend = 0;
        end else if (fr && !m_pend) begin m_pend = 1; m_pend_pc = pc; end
      end
    end
    #1;
    chk("flush_o", 32'(bus.flush_o), 32'(m_flush));
    chk("new_pc_o", bus.new_pc_o, m_pc);
    chk("fault_o", 32'(bus.fault_o), 32'(m_fault));
`ifdef STALL_PERF_EN
    chk("perf", bus.perf_stall_cnt_o, m_perf);
`endif
  endtask
  initial begin
    @(posedge clk); #1;
    step(1, 1, 1, 1, 1, 32'hDEAD);
    step(1, 1, 1, 1, 1, 32'hDEAD);
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_newpc", bus.new_pc_o, 0);
    step(0, 1, 0, 0, 0, 0); chk("prio_id", 32'(bus.stall_o), 32'h07);
    step(0, 1, 1, 0, 0, 0); chk("prio_ex", 32'(bus.stall_o), 32'h0F);
    step(0, 1, 0, 1, 0, 0); chk("prio_mem", 32'(bus.stall_o), 32'h1F);
    step(0, 0, 0, 0, 0, 0); chk("prio_none", 32'(bus.stall_o), 32'h00);
    step(0, 0, 0, 0, 1, 32'h1000);
    chk("t3_flush", 32'(bus.flush_o), 1);
    chk("t3_pc", bus.new_pc_o, 32'h1000);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_pulse", 32'(bus.flush_o), 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h2000);
    step(0, 0, 0, 1, 1, 32'h3000);
    chk("t4_defer", 32'(bus.flush_o), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_flush", 32'(bus.flush_o), 1);
    chk("t4_pc", bus.new_pc_o, 32'h2000);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_nofault", 32'(bus.fault_o), 0);
    repeat (4) step(0, 0, 0, 1, 0, 0);
    chk("t5_fault", 32'(bus.fault_o), 1);
    step(0, 0, 0, 0, 1, 32'h4000);
    chk("t5_lock", 32'(bus.stall_o), 32'h3F);
    step(1, 0, 0, 0, 0, 0);
    chk("t5_clear", 32'(bus.fault_o), 0);
`ifdef STALL_PERF_EN
    repeat (5) step(0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("t6_perf", bus.perf_stall_cnt_o, 5);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_rst", bus.perf_stall_cnt_o, 0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0 || (m_fault && $urandom_range(9) == 0),
           $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(9) < 4,
           $urandom_range(4) == 0, $urandom);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
